trans_cntr_flush: RTL and testbench

- Upstream feeder of the transition-counter memory.
- Counts logic transitions on NUM_CNTR monitored signals, one 32-bit counter per signal.
- On a flush request, snapshots all counters, clears the live counters, and writes each snapshot word to memory address i over the dir/LE/dato bus.
- Uses the memory's level-sensitive protocol: LE high = read/idle, LE low = write.

---
 rtl/trans_cntr_flush.sv | 139 +++++++++++++
 tb/tb_trans_cntr_flush.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_cntr_flush.sv
// Transition counters for NUM_CNTR signals, dumped to memory words 0..NUM_CNTR-1 on flush.
// Define TRANS_SAT_EN for saturating counters; otherwise counters wrap modulo 2^32.
module trans_cntr_flush #(
  parameter int NUM_CNTR = 5,
  parameter int DIR_W    = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [NUM_CNTR-1:0] sig,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [DIR_W-1:0]    dir,
  output logic                LE,
  inout  wire  [31:0]         dato
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [DIR_W-1:0]           k_q, k_d;
  logic [NUM_CNTR-1:0]        sig_q, sig_d;
  logic                       prime_q, prime_d;
  logic [NUM_CNTR-1:0][31:0]  cntr_q, cntr_d;
  logic [NUM_CNTR-1:0][31:0]  shadow_q, shadow_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       le_q, le_d;
  logic                       drive_q, drive_d;
  logic [DIR_W-1:0]           dir_q, dir_d;
  logic [NUM_CNTR-1:0]        inc;
  logic                       accept;
  logic [31:0]                word;

  // An event seen in the acceptance cycle seeds the fresh counter with 1.
  always_comb begin
    sig_d    = sig;
    prime_d  = 1'b1;
    inc      = prime_q ? (sig ^ sig_q) : '0;
    accept   = (state_q == S_IDLE) && flush;
    cntr_d   = cntr_q;
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (accept) begin
        shadow_d[i] = cntr_q[i];
        cntr_d[i]   = {31'b0, inc[i]};
      end else if (inc[i]) begin
`ifdef TRANS_SAT_EN
        if (cntr_q[i] != 32'hFFFF_FFFF) begin
          cntr_d[i] = cntr_q[i] + 32'd1;
        end
`else
        cntr_d[i] = cntr_q[i] + 32'd1;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          k_d     = '0;
        end
      end
      S_SETUP: state_d = S_WRITE;
      S_WRITE: state_d = S_HOLD;
      S_HOLD: begin
        if (k_q == DIR_W'(NUM_CNTR - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + DIR_W'(1);
          state_d = S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_HOLD);
    done_d  = (state_q == S_DONE);
    le_d    = (state_q != S_WRITE);
    drive_d = busy_d;
    dir_d   = busy_d ? k_q : '0;
  end

  // Outputs lag the state by one cycle so address/data settle before LE drops.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      sig_q    <= '0;
      prime_q  <= 1'b0;
      cntr_q   <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      le_q     <= 1'b1;
      drive_q  <= 1'b0;
      dir_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      sig_q    <= sig_d;
      prime_q  <= prime_d;
      cntr_q   <= cntr_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      le_q     <= le_d;
      drive_q  <= drive_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (dir_q == DIR_W'(i)) begin
        word = shadow_q[i];
      end
    end
  end

  assign dato = drive_q ? word : 32'bz;
  assign busy = busy_q;
  assign done = done_q;
  assign LE   = le_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_trans_cntr_flush.sv
// Self-checking bench for trans_cntr_flush: cycle model of counts and the write sequence,
// plus a memory model that captures words whenever LE is low.
module tb_trans_cntr_flush;

  localparam int NC      = 5;
  localparam int DW      = 4;
  localparam int SEQ_LEN = 3 * NC + 1;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          flush = 1'b0;
  logic [NC-1:0] sig = '0;
  logic          busy;
  logic          done;
  logic          LE;
  logic [DW-1:0] dir;
  wire  [31:0]   dato;

  // A released bus reads as all ones.
  pullup (dato);

  trans_cntr_flush #(.NUM_CNTR(NC), .DIR_W(DW)) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .sig    (sig),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .dir    (dir),
    .LE     (LE),
    .dato   (dato)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts per signal, snapshot, and cycles since acceptance.
  logic [31:0]   mdl_cnt    [NC];
  logic [31:0]   mdl_shadow [NC];
  logic [NC-1:0] mdl_prev;
  logic          mdl_prime = 1'b0;
  logic          mdl_active = 1'b0;
  int            mdl_n = 0;
  int            cyc = 0;
  int            acc_edge = 0;

  always @(posedge clk) begin
    logic idle_now;
    logic accept;
    logic ev;
    cyc++;
    if (!reset_L) begin
      for (int i = 0; i < NC; i++) begin
        mdl_cnt[i]    = '0;
        mdl_shadow[i] = '0;
      end
      mdl_prev   = '0;
      mdl_prime  = 1'b0;
      mdl_active = 1'b0;
      mdl_n      = 0;
    end else begin
      idle_now = !mdl_active || (mdl_n >= SEQ_LEN);
      if (mdl_active) mdl_n++;
      accept = flush && idle_now;
      for (int i = 0; i < NC; i++) begin
        ev = mdl_prime && (sig[i] != mdl_prev[i]);
        if (accept) begin
          mdl_shadow[i] = mdl_cnt[i];
          mdl_cnt[i]    = ev ? 32'd1 : 32'd0;
        end else if (ev) begin
`ifdef TRANS_SAT_EN
          if (mdl_cnt[i] != 32'hFFFF_FFFF) mdl_cnt[i] = mdl_cnt[i] + 32'd1;
`else
          mdl_cnt[i] = mdl_cnt[i] + 32'd1;
`endif
        end
      end
      if (accept) begin
        mdl_active = 1'b1;
        mdl_n      = 0;
        acc_edge   = cyc;
      end
      mdl_prime = 1'b1;
      mdl_prev  = sig;
    end
  end

  // Per-cycle comparison against the model, plus memory capture and event counters.
  logic        chk_en = 1'b0;
  logic [31:0] mem [16];
  int          le_low_cnt = 0;
  int          done_cnt = 0;
  int          busy_rises = 0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    logic        in_seq;
    int          w;
    logic [31:0] e_dato;
    if (chk_en) begin
      in_seq = mdl_active && (mdl_n >= 1) && (mdl_n <= SEQ_LEN - 1);
      w      = in_seq ? (mdl_n - 1) / 3 : 0;
      e_dato = in_seq ? mdl_shadow[w] : 32'hFFFF_FFFF;
      checkOutput("busy", {31'b0, busy}, {31'b0, in_seq});
      checkOutput("done", {31'b0, done}, {31'b0, mdl_active && (mdl_n == SEQ_LEN)});
      checkOutput("LE", {31'b0, LE}, {31'b0, !(in_seq && ((mdl_n - 1) % 3 == 1))});
      checkOutput("dir", {28'b0, dir}, 32'(w));
      checkOutput("dato", dato, e_dato);
      if (LE === 1'b0) begin
        le_low_cnt++;
        mem[dir] = dato;
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1 && !prev_busy) busy_rises++;
      prev_busy = (busy === 1'b1);
    end
  end

  logic [NC-1:0] s = '0;
  int            done_edge = 0;

  task automatic applyStimulus(input logic rst_n, input logic [NC-1:0] s_in, input logic fl);
    reset_L = rst_n;
    sig     = s_in;
    flush   = fl;
    @(negedge clk);
  endtask

  task automatic waitDone(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus(1'b1, s, 1'b0);
      if (done === 1'b1) begin
        seen      = 1'b1;
        done_edge = cyc;
      end
    end
    checkOutput(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  initial begin
    logic [NC-1:0][31:0] fv;

    // Reset state
    applyStimulus(1'b0, s, 1'b0);
    applyStimulus(1'b0, s, 1'b0);
    chk_en = 1'b1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_LE", {31'b0, LE}, 32'd1);
    checkOutput("rst_dir", {28'b0, dir}, 32'd0);
    checkOutput("rst_dato", dato, 32'hFFFF_FFFF);

    // sig[0] toggles 10 times, then a single dump
    applyStimulus(1'b1, s, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s[0] = ~s[0];
      applyStimulus(1'b1, s, 1'b0);
    end
    clearMem();
    le_low_cnt = 0;
    applyStimulus(1'b1, s, 1'b1);
    waitDone("t1_done_seen");
    checkOutput("t1_word0", mem[0], 32'd10);
    for (int i = 1; i < NC; i++) checkOutput("t1_word_zero", mem[i], 32'd0);
    checkOutput("t1_done_latency", 32'(done_edge - acc_edge), 32'd16);
    checkOutput("t1_le_low_cycles", 32'(le_low_cnt), 32'd5);

    // sig[2]: 3 toggles before, 4 during the sequence, then back-to-back flush
    for (int i = 0; i < 3; i++) begin
      s[2] = ~s[2];
      applyStimulus(1'b1, s, 1'b0);
    end
    applyStimulus(1'b1, s, 1'b0);
    applyStimulus(1'b1, s, 1'b1);
    for (int i = 0; i < 4; i++) begin
      s[2] = ~s[2];
      applyStimulus(1'b1, s, 1'b0);
    end
    waitDone("t2_done1_seen");
    checkOutput("t2_dump1_word2", mem[2], 32'd3);
    applyStimulus(1'b1, s, 1'b1);
    checkOutput("t2_accept_after_done", 32'(acc_edge - done_edge), 32'd1);
    waitDone("t2_done2_seen");
    checkOutput("t2_dump2_word2", mem[2], 32'd4);

    // Transition on sig[1] in the acceptance cycle goes to the next dump
    for (int i = 0; i < 2; i++) begin
      s[1] = ~s[1];
      applyStimulus(1'b1, s, 1'b0);
    end
    applyStimulus(1'b1, s, 1'b0);
    s[1] = ~s[1];
    applyStimulus(1'b1, s, 1'b1);
    waitDone("t3_done1_seen");
    checkOutput("t3_dump1_word1", mem[1], 32'd2);
    applyStimulus(1'b1, s, 1'b1);
    waitDone("t3_done2_seen");
    checkOutput("t3_dump2_word1", mem[1], 32'd1);

    // Flush re-asserted mid-sequence is ignored
    applyStimulus(1'b1, s, 1'b0);
    done_cnt   = 0;
    busy_rises = 0;
    applyStimulus(1'b1, s, 1'b1);
    for (int i = 1; i <= 18; i++) applyStimulus(1'b1, s, (i == 3) || (i == 9));
    applyStimulus(1'b1, s, 1'b0);
    checkOutput("t4_done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("t4_busy_rises", 32'(busy_rises), 32'd1);

    // Reset while word 2 is being written
    s[0] = ~s[0];
    s[4] = ~s[4];
    applyStimulus(1'b1, s, 1'b0);
    clearMem();
    applyStimulus(1'b1, s, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, s, 1'b0);
    checkOutput("t5_LE_write2", {31'b0, LE}, 32'd0);
    checkOutput("t5_dir_write2", {28'b0, dir}, 32'd2);
    applyStimulus(1'b0, s, 1'b0);
    checkOutput("t5_rst_LE", {31'b0, LE}, 32'd1);
    checkOutput("t5_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("t5_rst_dato", dato, 32'hFFFF_FFFF);
    applyStimulus(1'b1, s, 1'b0);
    checkOutput("t5_word3_unwritten", mem[3], 32'hDEAD_BEEF);
    checkOutput("t5_word4_unwritten", mem[4], 32'hDEAD_BEEF);
    applyStimulus(1'b1, s, 1'b0);
    applyStimulus(1'b1, s, 1'b1);
    waitDone("t5_done_seen");
    for (int i = 0; i < NC; i++) checkOutput("t5_cleared_word", mem[i], 32'd0);

    // Counter overflow near 2^32
    applyStimulus(1'b1, s, 1'b0);
    mdl_cnt[3] = 32'hFFFF_FFFE;
    for (int i = 0; i < NC; i++) fv[i] = mdl_cnt[i];
    force dut.cntr_q = fv;
    #1;
    release dut.cntr_q;
    for (int i = 0; i < 3; i++) begin
      s[3] = ~s[3];
      applyStimulus(1'b1, s, 1'b0);
    end
    applyStimulus(1'b1, s, 1'b1);
    waitDone("t6_done_seen");
`ifdef TRANS_SAT_EN
    checkOutput("t6_word3_sat", mem[3], 32'hFFFF_FFFF);
`else
    checkOutput("t6_word3_wrap", mem[3], 32'h0000_0001);
`endif
    applyStimulus(1'b1, s, 1'b0);
    applyStimulus(1'b1, s, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
